// File: rtl/adc_trigger_capture_pkg.sv
// Shared definitions for the ADC trigger/capture block.
//   - default sample width and capture depth
//   - depth of the ADC-clock synchronizer
//   - capture FSM state encoding
package adc_trigger_capture_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/adc_trigger_capture_if.sv
// Signal bundle between the ADC front end / host bridge and the capture block.
//   master: drives ADC clock/data, control pulses, trigger config, read address
//   slave : the capture block; returns read data, status and trigger position
interface adc_trigger_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              adc_clk_in;
  logic [DATA_W-1:0] adc_data_in;
  logic              arm;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic              trig_falling;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              armed;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_pos;

  modport master (
    output adc_clk_in, adc_data_in, arm, force_trig, trig_level, trig_falling, rd_addr,
    input  rd_data, armed, busy, done, trig_pos
  );

  modport slave (
    input  adc_clk_in, adc_data_in, arm, force_trig, trig_level, trig_falling, rd_addr,
    output rd_data, armed, busy, done, trig_pos
  );
endinterface

// File: rtl/adc_trigger_capture_capture_ram.sv
// capture_ram: simple dual-port sample buffer, DATA_W x 2**ADDR_W.
//   CLK, RST_n        : clock, synchronous active-low reset (read register only)
//   wr_en/addr/data   : capture write port
//   rd_addr / rd_data : readout port, registered, 1-cycle latency
// Memory contents are never reset so the array maps onto block RAM.
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register reset maps onto the BRAM output-latch reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) rd_data_reg <= '0;
    else        rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;
endmodule

// File: rtl/adc_trigger_capture.sv
// adc_trigger_capture: arms on request, waits for a level crossing of the ADC
// sample stream, then records 2**ADDR_W samples into on-chip RAM for readout.
//   CLK   : system clock (ADC clock/data already registered in this domain)
//   RST_n : synchronous active-low reset
//   bus   : slave side of adc_trigger_capture_if (ADC input, control, status, readout)
module adc_trigger_capture
  import adc_trigger_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                  CLK,
  input logic                  RST_n,
  adc_trigger_capture_if.slave bus
);

  logic [SYNC_DEPTH-1:0] sync_reg;
  logic                  s2_prev_reg;
  logic                  strobe;
  logic [DATA_W-1:0]     prev_sample_reg;
  logic                  prev_valid_reg;
  state_t                state_reg;
  logic [ADDR_W-1:0]     wr_ptr_reg;
  logic                  armed_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  rise_hit;
  logic                  fall_hit;
  logic                  trig_hit;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;

  // Sample on the falling edge of the ADC clock: the data bus changes just
  // after the rising edge, so mid-period it is guaranteed stable.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      sync_reg    <= '0;
      s2_prev_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_DEPTH-2:0], bus.adc_clk_in};
      s2_prev_reg <= sync_reg[SYNC_DEPTH-1];
    end
  end

  assign strobe = s2_prev_reg & ~sync_reg[SYNC_DEPTH-1];

  // Level-crossing detection between the previous sample and the one
  // presented on this strobe; unsigned compares.
  assign rise_hit = (prev_sample_reg <  bus.trig_level) && (bus.adc_data_in >= bus.trig_level);
  assign fall_hit = (prev_sample_reg >= bus.trig_level) && (bus.adc_data_in <  bus.trig_level);
  assign trig_hit = strobe && prev_valid_reg && (state_reg == ARMED) &&
                    (bus.trig_falling ? fall_hit : rise_hit);

  // The triggering sample itself is the first word of the burst (address 0).
  assign wr_en   = RST_n && strobe && (trig_hit || (state_reg == CAPTURE));
  assign wr_addr = (state_reg == CAPTURE) ? wr_ptr_reg : '0;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      prev_sample_reg <= '0;
      prev_valid_reg  <= 1'b0;
      armed_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      if (strobe) prev_sample_reg <= bus.adc_data_in;

      case (state_reg)
        IDLE: begin
          if (bus.arm) begin
            state_reg      <= ARMED;
            prev_valid_reg <= 1'b0;
            armed_reg      <= 1'b1;
          end
        end

        ARMED: begin
          if (trig_hit) begin
            state_reg  <= CAPTURE;
            wr_ptr_reg <= ADDR_W'(1);
            armed_reg  <= 1'b0;
            busy_reg   <= 1'b1;
          end else if (bus.force_trig) begin
            state_reg  <= CAPTURE;
            wr_ptr_reg <= '0;
            armed_reg  <= 1'b0;
            busy_reg   <= 1'b1;
          end else if (strobe) begin
            // First sample after arming only seeds prev_sample.
            prev_valid_reg <= 1'b1;
          end
        end

        CAPTURE: begin
          if (strobe) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (wr_ptr_reg == '1) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end

        DONE: begin
          if (bus.arm) begin
            state_reg      <= ARMED;
            prev_valid_reg <= 1'b0;
            armed_reg      <= 1'b1;
            done_reg       <= 1'b0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.adc_data_in),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.armed    = armed_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.trig_pos = '0;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Testbench for adc_trigger_capture (ADDR_W = 4, 16-sample bursts).
// Stimulus drives one ADC period at a time and advances a sample-level
// reference model; expected status and read data go into queues that a
// separate monitor pops and compares.
module tb_adc_trigger_capture;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_CAP   = 2;
  localparam int M_DONE  = 3;

  logic CLK;
  logic RST_n;

  adc_trigger_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  adc_trigger_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues
  logic [7:0] rd_exp_q [$];
  int         rd_addr_q [$];
  logic [2:0] st_exp_q [$];
  string      st_tag_q [$];
  logic rd_req = 1'b0, st_req = 1'b0;
  logic rd_check_q = 1'b0, st_check_q = 1'b0;

  // Reference model: behaviour at the granularity of whole ADC samples.
  int         m_mode = M_IDLE;
  int         m_seen = 0;     // samples observed since arming
  int         m_idx  = 0;     // next burst position
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] cfg_level = 8'h80;
  bit         cfg_falling = 1'b0;

  task automatic model_period(input logic [7:0] s, input bit do_arm, input bit do_force);
    bit hit;
    if (do_arm && (m_mode == M_IDLE || m_mode == M_DONE)) begin
      m_mode = M_ARMED;
      m_seen = 0;
    end
    if (do_force && m_mode == M_ARMED) begin
      m_mode = M_CAP;
      m_idx  = 0;
    end
    if (m_mode == M_ARMED) begin
      hit = (m_seen > 0) &&
            (cfg_falling ? (m_prev >= cfg_level && s < cfg_level)
                         : (m_prev <  cfg_level && s >= cfg_level));
      m_seen++;
      if (hit) begin
        m_mode = M_CAP;
        m_idx  = 0;
      end
    end
    if (m_mode == M_CAP) begin
      m_mem[m_idx] = s;
      m_idx++;
      if (m_idx == DEPTH) m_mode = M_DONE;
    end
    m_prev = s;
  endtask

  function automatic logic [2:0] model_status();
    return {m_mode == M_ARMED, m_mode == M_CAP, m_mode == M_DONE};
  endfunction

  // Monitor
  always @(posedge CLK) begin
    rd_check_q <= rd_req;
    st_check_q <= st_req;
  end

  always @(negedge CLK) begin
    logic [7:0] e;
    logic [2:0] es;
    int a;
    string t;
    if (rd_check_q) begin
      n_checks++;
      if (rd_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data: data %02h presented with nothing expected", bus_if.rd_data);
      end else begin
        e = rd_exp_q.pop_front();
        a = rd_addr_q.pop_front();
        if (bus_if.rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data[%0d]: actual=%02h required=%02h", a, bus_if.rd_data, e);
        end else
          $display("read  addr=%0d data=%02h", a, bus_if.rd_data);
      end
    end
    if (st_check_q) begin
      n_checks++;
      if (st_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL status: sampled with nothing expected");
      end else begin
        es = st_exp_q.pop_front();
        t  = st_tag_q.pop_front();
        if ({bus_if.trig_pos, bus_if.armed, bus_if.busy, bus_if.done} !== {4'd0, es}) begin
          n_fail++;
          $display("FAIL status %s: actual trig_pos=%0d armed/busy/done=%b%b%b required trig_pos=0 %b",
                   t, bus_if.trig_pos, bus_if.armed, bus_if.busy, bus_if.done, es);
        end else
          $display("status %s armed/busy/done=%b", t, es);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_status(input string tag);
    st_exp_q.push_back(model_status());
    st_tag_q.push_back(tag);
    st_req = 1'b1;
  endtask

  task automatic set_cfg(input logic [7:0] lvl, input bit falling);
    cfg_level = lvl;
    cfg_falling = falling;
    bus_if.trig_level = lvl;
    bus_if.trig_falling = falling;
  endtask

  // One ADC period: 4 CLK high, 5 CLK low. Arm/force pulses land in the
  // high phase, i.e. before this period's sample strobe.
  task automatic adc_period(input logic [7:0] s, input bit do_arm, input bit do_force, input string tag);
    bus_if.adc_clk_in  = 1'b1;
    bus_if.adc_data_in = s;
    bus_if.arm         = do_arm;
    bus_if.force_trig  = do_force;
    step();
    bus_if.arm        = 1'b0;
    bus_if.force_trig = 1'b0;
    repeat (3) step();
    bus_if.adc_clk_in = 1'b0;
    repeat (4) step();
    model_period(s, do_arm, do_force);
    push_status(tag);
    step();
    st_req = 1'b0;
  endtask

  task automatic read_addr(input int a);
    bus_if.rd_addr = ADDR_W'(a);
    rd_exp_q.push_back(m_mem[a]);
    rd_addr_q.push_back(a);
    rd_req = 1'b1;
    step();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) read_addr(a);
    rd_req = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    RST_n = 1'b0;
    bus_if.adc_clk_in = 1'b0;
    bus_if.adc_data_in = '0;
    bus_if.arm = 1'b0;
    bus_if.force_trig = 1'b0;
    bus_if.trig_level = 8'h80;
    bus_if.trig_falling = 1'b0;
    bus_if.rd_addr = '0;

    // 1. Reset with the ADC clock running
    step();
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) bus_if.adc_clk_in = ~bus_if.adc_clk_in;
      if (i == 9) begin
        rd_exp_q.push_back(8'h00);
        rd_addr_q.push_back(0);
        rd_req = 1'b1;
        push_status("in_reset");
      end
      step();
      rd_req = 1'b0;
      st_req = 1'b0;
    end
    bus_if.adc_clk_in = 1'b0;
    RST_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) adc_period(8'h90, 1'b0, 1'b0, "idle_no_arm");

    // 2. Rising trigger on a ramp
    set_cfg(8'h80, 1'b0);
    for (int k = 0; k < 18; k++)
      adc_period(8'(8'h70 + 8 * k), k == 0, 1'b0, "ramp_rise");
    read_all();

    // 3. Falling trigger, first sample after arming cannot trigger
    set_cfg(8'h40, 1'b1);
    adc_period(8'h30, 1'b1, 1'b0, "fall_first");
    for (int i = 0; i < 3; i++) adc_period(8'h30, 1'b0, 1'b0, "fall_hold");
    adc_period(8'h50, 1'b0, 1'b0, "fall_above");
    adc_period(8'h3F, 1'b0, 1'b0, "fall_trig");
    for (int i = 0; i < 15; i++) adc_period(8'($urandom_range(0, 255)), 1'b0, 1'b0, "fall_cap");
    read_all();

    // 4. Forced trigger with constant input
    set_cfg(8'h80, 1'b0);
    adc_period(8'h55, 1'b1, 1'b0, "force_arm");
    for (int i = 0; i < 16; i++) adc_period(8'h55, 1'b0, i == 0, "force_cap");
    read_all();

    // 5. Reset part way through a capture, then a clean capture
    adc_period(8'h10, 1'b1, 1'b0, "rst_arm");
    for (int i = 0; i < 5; i++) adc_period(8'(8'h20 + i), 1'b0, i == 0, "rst_cap");
    RST_n = 1'b0;
    m_mode = M_IDLE;
    push_status("after_reset");
    step();
    st_req = 1'b0;
    RST_n = 1'b1;
    adc_period(8'hA0, 1'b1, 1'b0, "rearm");
    for (int i = 0; i < 16; i++) adc_period(8'($urandom_range(0, 255)), 1'b0, i == 0, "recap");
    read_all();

    // 6. Back-to-back reads in DONE, then re-arm from DONE
    read_addr(3);
    read_addr(7);
    rd_req = 1'b0;
    adc_period(8'h00, 1'b1, 1'b0, "rearm_done");

    // Randomized runs: random level/direction/samples, stray arm/force pulses
    for (int r = 0; r < 4; r++) begin
      set_cfg(8'($urandom_range(32, 224)), bit'($urandom_range(0, 1)));
      for (int i = 0; i < 80; i++) begin
        if (i > 0 && m_mode == M_DONE) break;
        s = 8'($urandom_range(0, 255));
        adc_period(s, (i == 0) || ($urandom_range(0, 7) == 0),
                   (i == 20) || ($urandom_range(0, 15) == 0), "random");
      end
      read_all();
    end

    repeat (4) step();
    n_checks++;
    if (rd_exp_q.size() != 0 || st_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual rd=%0d st=%0d pending, required 0",
               rd_exp_q.size(), st_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
